// File: rtl/dws_conv_stream.sv
// dws_conv_stream: depthwise-separable 1-D convolution over CH streamed channels with ready/valid handshakes.
// Define DWS_CONV_RELU_EN to clamp negative results to zero before they are registered.
module dws_conv_stream #(
    parameter int CH = 3,
    parameter int DW = 5,
    parameter int KW = 8,
    parameter int KTAPS = 7,
    parameter int FRAME_LEN = 100,
    parameter int OW = 32
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 IN_VALID,
    output logic                 IN_READY,
    input  logic [CH*DW-1:0]     IN_DATA,
    input  logic                 KERNEL_VALID,
    input  logic signed [KW-1:0] KERNEL,
    output logic                 OUT_VALID,
    input  logic                 OUT_READY,
    output logic signed [OW-1:0] OUT_DATA,
    output logic                 FRAME_DONE,
    output logic                 KERNEL_ERR
);
    localparam int NDW = CH * KTAPS;
    localparam int NK = NDW + CH;
    localparam int SW = DW + 1 + KW + $clog2(KTAPS);
    localparam int TW = SW + KW + $clog2(CH);
    localparam int KCW = $clog2(NK);
    localparam int SCW = $clog2(FRAME_LEN + 1);
    localparam logic [0:0] S_LOAD = 1'b0;
    localparam logic [0:0] S_RUN = 1'b1;

    if (OW < TW) begin : g_ow_check
        $error("dws_conv_stream: OW is narrower than the full-precision result");
    end

    logic [0:0] state;
    logic [KCW-1:0] kw_cnt;
    logic [SCW-1:0] sample_cnt;
    logic signed [KW-1:0] kern [NK];
    logic [DW-1:0] win [CH][KTAPS];
    logic [DW-1:0] nxt [CH][KTAPS];
    logic signed [SW-1:0] csum [CH];
    logic signed [TW-1:0] tot;
    logic signed [OW-1:0] res;
    logic reload, accept, last, emit;

    // A reload word owns its cycle, so no sample slips into a window that is about to be retired
    assign reload = state == S_RUN && KERNEL_VALID && sample_cnt == '0 && !OUT_VALID;
    assign IN_READY = state == S_RUN && (!OUT_VALID || OUT_READY) && !reload;
    assign accept = IN_VALID && IN_READY;
    assign last = sample_cnt == SCW'(FRAME_LEN - 1);
    assign emit = accept && sample_cnt >= SCW'(KTAPS - 1);

    // Window index 0 holds the oldest sample; the result covers the window after this cycle's shift
    always_comb begin
        tot = '0;
        for (int c = 0; c < CH; c++) begin
            csum[c] = '0;
            for (int k = 0; k < KTAPS; k++) begin
                nxt[c][k] = (k == KTAPS - 1) ? IN_DATA[c*DW +: DW] : win[c][(k + 1) % KTAPS];
                csum[c] = csum[c] + SW'($signed({1'b0, nxt[c][k]})) * SW'(kern[c*KTAPS + k]);
            end
            tot = tot + TW'(csum[c]) * TW'(kern[NDW + c]);
        end
    end

`ifdef DWS_CONV_RELU_EN
    assign res = tot[TW-1] ? '0 : OW'(tot);
`else
    assign res = OW'(tot);
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= S_LOAD;
            kw_cnt <= '0;
            sample_cnt <= '0;
            OUT_VALID <= 1'b0;
            OUT_DATA <= '0;
            FRAME_DONE <= 1'b0;
            KERNEL_ERR <= 1'b0;
            for (int c = 0; c < CH; c++)
                for (int k = 0; k < KTAPS; k++)
                    win[c][k] <= '0;
        end else begin
            FRAME_DONE <= accept && last;
            if (emit) begin
                OUT_DATA <= res;
                OUT_VALID <= 1'b1;
            end else if (OUT_READY) begin
                OUT_VALID <= 1'b0;
            end
            if (state == S_LOAD) begin
                if (KERNEL_VALID) begin
                    kern[kw_cnt] <= KERNEL;
                    kw_cnt <= (kw_cnt == KCW'(NK - 1)) ? '0 : kw_cnt + 1'b1;
                    if (kw_cnt == KCW'(NK - 1))
                        state <= S_RUN;
                end
            end else if (reload) begin
                kern[0] <= KERNEL;
                kw_cnt <= KCW'(1);
                state <= S_LOAD;
            end else if (KERNEL_VALID) begin
                KERNEL_ERR <= 1'b1;
            end
            if (accept) begin
                sample_cnt <= last ? '0 : sample_cnt + 1'b1;
                for (int c = 0; c < CH; c++)
                    for (int k = 0; k < KTAPS; k++)
                        win[c][k] <= last ? '0 : nxt[c][k];
            end
        end
    end
endmodule

// File: tb/tb_dws_conv_stream.sv
// tb_dws_conv_stream: directed frames with random data and backpressure, checked against an arithmetic window model.
module tb_dws_conv_stream;
    localparam int CH = 3;
    localparam int DW = 5;
    localparam int KW = 8;
    localparam int KTAPS = 7;
    localparam int FRAME_LEN = 100;
    localparam int OW = 32;
    localparam int NK = CH * KTAPS + CH;
    localparam int NOUT = FRAME_LEN - KTAPS + 1;

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    logic IN_VALID = 1'b0;
    logic IN_READY;
    logic [CH*DW-1:0] IN_DATA = '0;
    logic KERNEL_VALID = 1'b0;
    logic signed [KW-1:0] KERNEL = '0;
    logic OUT_VALID;
    logic OUT_READY = 1'b1;
    logic signed [OW-1:0] OUT_DATA;
    logic FRAME_DONE;
    logic KERNEL_ERR;

    int checks = 0;
    int errors = 0;
    int n_out = 0;
    int stall_cnt = 0;
    bit rdy_rand = 1'b0;
    bit hold_chk = 1'b0;
    logic signed [OW-1:0] held = '0;
    int dwk [CH][KTAPS];
    int pwk [CH];
    int xs [CH][FRAME_LEN];
    logic signed [63:0] exp_q [$];

    dws_conv_stream #(.CH(CH), .DW(DW), .KW(KW), .KTAPS(KTAPS), .FRAME_LEN(FRAME_LEN), .OW(OW)) dut (
        .CLK(CLK),
        .RESET(RESET),
        .IN_VALID(IN_VALID),
        .IN_READY(IN_READY),
        .IN_DATA(IN_DATA),
        .KERNEL_VALID(KERNEL_VALID),
        .KERNEL(KERNEL),
        .OUT_VALID(OUT_VALID),
        .OUT_READY(OUT_READY),
        .OUT_DATA(OUT_DATA),
        .FRAME_DONE(FRAME_DONE),
        .KERNEL_ERR(KERNEL_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, want);
        end
    endtask

    // Output p is the dot product of every channel's kernel with samples p..p+KTAPS-1, then pointwise-weighted
    function automatic longint model(input int p);
        longint s = 0;
        for (int c = 0; c < CH; c++) begin
            longint d = 0;
            for (int k = 0; k < KTAPS; k++)
                d += longint'(dwk[c][k]) * xs[c][p + k];
            s += d * pwk[c];
        end
`ifdef DWS_CONV_RELU_EN
        if (s < 0) s = 0;
`endif
        return s;
    endfunction

    task automatic set_kernel(input int dwv, input int pwv, input bit rnd);
        for (int c = 0; c < CH; c++) begin
            for (int k = 0; k < KTAPS; k++)
                dwk[c][k] = rnd ? int'($urandom_range(0, 255)) - 128 : dwv;
            pwk[c] = rnd ? int'($urandom_range(0, 255)) - 128 : pwv;
        end
    endtask

    task automatic set_input(input int v, input bit rnd);
        for (int c = 0; c < CH; c++)
            for (int i = 0; i < FRAME_LEN; i++)
                xs[c][i] = rnd ? int'($urandom_range(0, 31)) : v;
    endtask

    task automatic load_kernel();
        int t = 0;
        while (OUT_VALID && t < 1000) begin
            @(posedge CLK); #1;
            t++;
        end
        chk("drain_before_load", OUT_VALID, 0);
        for (int w = 0; w < NK; w++) begin
            if ($urandom_range(0, 3) == 0) begin
                KERNEL_VALID = 1'b0;
                @(posedge CLK); #1;
            end
            KERNEL_VALID = 1'b1;
            KERNEL = KW'(w < CH * KTAPS ? dwk[w / KTAPS][w % KTAPS] : pwk[w - CH * KTAPS]);
            if (w > 0) begin
                IN_VALID = 1'b1;
                IN_DATA = (CH*DW)'($urandom);
            end
            @(negedge CLK);
            if (w > 0) chk("load_in_ready", IN_READY, 0);
            @(posedge CLK); #1;
        end
        KERNEL_VALID = 1'b0;
        IN_VALID = 1'b0;
    endtask

    task automatic run_frame(input int ns, input bit strict, input int kerr_at, input int stall_at);
        int t;
        int start = n_out;
        for (int p = 0; p < NOUT; p++) exp_q.push_back(model(p));
        for (int i = 0; i < ns; i++) begin
            IN_VALID = 1'b1;
            for (int c = 0; c < CH; c++) IN_DATA[c*DW +: DW] = DW'(xs[c][i]);
            KERNEL_VALID = (i == kerr_at);
            KERNEL = 8'sh5a;
            t = 0;
            @(negedge CLK);
            while (!IN_READY && t < 1000) begin
                @(negedge CLK);
                t++;
            end
            if (!IN_READY) begin
                chk("in_ready_timeout", IN_READY, 1);
                IN_VALID = 1'b0;
                KERNEL_VALID = 1'b0;
                return;
            end
            if (i == stall_at) stall_cnt = 5;
            @(posedge CLK); #1;
            IN_VALID = 1'b0;
            KERNEL_VALID = 1'b0;
            if (strict) chk("out_valid_latency", OUT_VALID, i >= KTAPS - 1);
            if (strict || i == FRAME_LEN - 1) chk("frame_done", FRAME_DONE, i == FRAME_LEN - 1);
        end
        if (ns == FRAME_LEN) begin
            t = 0;
            while (exp_q.size() != 0 && t < 1000) begin
                @(posedge CLK); #1;
                t++;
            end
            chk("frame_outputs", n_out - start, NOUT);
        end
    endtask

    always @(posedge CLK) begin
        #2;
        OUT_READY = rdy_rand ? ($urandom_range(0, 3) != 0) : (stall_cnt == 0);
        if (stall_cnt > 0) stall_cnt--;
    end

    always @(negedge CLK) begin
        if (hold_chk) begin
            chk("hold_valid", OUT_VALID, 1);
            chk("hold_data", $signed(OUT_DATA), $signed(held));
        end
        hold_chk = OUT_VALID && !OUT_READY && !RESET;
        held = OUT_DATA;
        if (OUT_VALID && !OUT_READY) chk("stall_in_ready", IN_READY, 0);
        if (OUT_VALID && OUT_READY) begin
            n_out++;
            if (exp_q.size() == 0) chk("extra_output", exp_q.size(), 1);
            else chk("out_data", $signed(OUT_DATA), exp_q.pop_front());
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;
        chk("rst_in_ready", IN_READY, 0);
        chk("rst_out_valid", OUT_VALID, 0);
        chk("rst_out_data", $signed(OUT_DATA), 0);
        chk("rst_frame_done", FRAME_DONE, 0);
        chk("rst_kernel_err", KERNEL_ERR, 0);

        set_kernel(1, 1, 1'b0);
        set_input(2, 1'b0);
        load_kernel();
        run_frame(FRAME_LEN, 1'b1, -1, -1);
        chk("kernel_err_clear", KERNEL_ERR, 0);

        set_kernel(0, 0, 1'b1);
        set_input(0, 1'b1);
        rdy_rand = 1'b1;
        load_kernel();
        run_frame(FRAME_LEN, 1'b0, 40, -1);
        rdy_rand = 1'b0;
        chk("kernel_err_set", KERNEL_ERR, 1);

        set_kernel(-128, -128, 1'b0);
        set_input(31, 1'b0);
        load_kernel();
        run_frame(FRAME_LEN, 1'b1, -1, -1);

        set_kernel(-128, 127, 1'b0);
        load_kernel();
        run_frame(FRAME_LEN, 1'b1, -1, -1);

        set_kernel(2, 1, 1'b0);
        set_input(2, 1'b0);
        load_kernel();
        run_frame(FRAME_LEN, 1'b1, -1, -1);

        set_kernel(0, 0, 1'b1);
        set_input(0, 1'b1);
        load_kernel();
        run_frame(FRAME_LEN, 1'b1, -1, 50);

        set_input(0, 1'b1);
        run_frame(50, 1'b0, -1, -1);
        RESET = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0;
        exp_q.delete();
        chk("mid_rst_in_ready", IN_READY, 0);
        chk("mid_rst_out_valid", OUT_VALID, 0);
        chk("mid_rst_out_data", $signed(OUT_DATA), 0);
        chk("mid_rst_frame_done", FRAME_DONE, 0);
        chk("mid_rst_kernel_err", KERNEL_ERR, 0);

        set_kernel(0, 0, 1'b1);
        set_input(0, 1'b1);
        rdy_rand = 1'b1;
        load_kernel();
        run_frame(FRAME_LEN, 1'b0, -1, -1);
        rdy_rand = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
